gpio_input_port: RTL

GPIO_INPUT_PORT -- requirements
Module: gpio_input_port

---
 rtl/gpio_input_port.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/gpio_input_port.sv
// Memory-mapped debounced GPIO input port with sticky edge flags and one
// level interrupt. Pins are synchronized, sampled on a slow tick and
// accepted only after three equal consecutive samples.
module gpio_input_port #(
   parameter int unsigned DATA_WIDTH   = 32,
   parameter int unsigned ADDR_WIDTH   = 8,
   parameter int unsigned IN_WIDTH     = 8,
   parameter int unsigned DEBOUNCE_MAX = 32'd500000
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [IN_WIDTH-1:0]   gpio_data_in,
   input  logic [ADDR_WIDTH-1:0] addr,
   input  logic                  we,
   input  logic                  re,
   input  logic [DATA_WIDTH-1:0] wdata,
   output logic [DATA_WIDTH-1:0] rdata,
   output logic                  irq
);

   localparam int unsigned CNT_W = (DEBOUNCE_MAX > 1) ? $clog2(DEBOUNCE_MAX) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_MAX - 1);

   localparam logic [ADDR_WIDTH-1:0] ADDR_DEB    = ADDR_WIDTH'(0);
   localparam logic [ADDR_WIDTH-1:0] ADDR_RISE   = ADDR_WIDTH'(1);
   localparam logic [ADDR_WIDTH-1:0] ADDR_FALL   = ADDR_WIDTH'(2);
   localparam logic [ADDR_WIDTH-1:0] ADDR_IRQ_EN = ADDR_WIDTH'(3);

   // synchronizer stages
   logic [IN_WIDTH-1:0]   sync_meta;
   logic [IN_WIDTH-1:0]   sync_q;

   // three-sample history: the sample taken at the current tick (sync_q)
   // plus the samples of the two previous ticks
   logic [IN_WIDTH-1:0]   hist_new;
   logic [IN_WIDTH-1:0]   hist_old;

   logic [CNT_W-1:0]      tick_cnt;
   logic [IN_WIDTH-1:0]   deb_q;
   logic [IN_WIDTH-1:0]   rise_q;
   logic [IN_WIDTH-1:0]   fall_q;
   logic [IN_WIDTH-1:0]   irq_en_q;

   logic                  tick_c;
   logic [IN_WIDTH-1:0]   eq_c;
   logic [IN_WIDTH-1:0]   deb_nxt_c;
   logic [IN_WIDTH-1:0]   rise_set_c;
   logic [IN_WIDTH-1:0]   fall_set_c;
   logic [IN_WIDTH-1:0]   rise_clr_c;
   logic [IN_WIDTH-1:0]   fall_clr_c;
   logic [DATA_WIDTH-1:0] rd_mux_c;
   logic                  irq_nxt_c;
   logic                  unused_wdata_c;

   // only wdata[IN_WIDTH-1:0] carries register content
   assign unused_wdata_c = ^wdata;

   // two-flop synchronizer on every pin
   always_ff @(posedge clk) begin
      if (reset) begin
         sync_meta <= '0;
         sync_q    <= '0;
      end else begin
         sync_meta <= gpio_data_in;
         sync_q    <= sync_meta;
      end
   end

   // free-running sample tick counter, wraps at DEBOUNCE_MAX-1
   always_ff @(posedge clk) begin
      if (reset) begin
         tick_cnt <= '0;
      end else if (tick_c) begin
         tick_cnt <= '0;
      end else begin
         tick_cnt <= tick_cnt + CNT_W'(1);
      end
   end

   assign tick_c = (tick_cnt == CNT_LAST);

   // debounce decision: accept the sample only when all three history
   // entries (including the one being taken now) agree; deb moves only on a tick
   always_comb begin
      eq_c      = ~(sync_q ^ hist_new) & ~(hist_new ^ hist_old);
      deb_nxt_c = deb_q;
      if (tick_c) begin
         deb_nxt_c = (deb_q & ~eq_c) | (sync_q & eq_c);
      end
   end

   // history shift on each tick
   always_ff @(posedge clk) begin
      if (reset) begin
         hist_new <= '0;
         hist_old <= '0;
      end else if (tick_c) begin
         hist_new <= sync_q;
         hist_old <= hist_new;
      end
   end

   // debounced level
   always_ff @(posedge clk) begin
      if (reset) begin
         deb_q <= '0;
      end else begin
         deb_q <= deb_nxt_c;
      end
   end

   // edge detection and W1C decode; a set in the same cycle beats the clear
   always_comb begin
      rise_set_c = deb_nxt_c & ~deb_q;
      fall_set_c = deb_q & ~deb_nxt_c;
      rise_clr_c = '0;
      fall_clr_c = '0;
      if (we && (addr == ADDR_RISE)) begin
         rise_clr_c = wdata[IN_WIDTH-1:0];
      end
      if (we && (addr == ADDR_FALL)) begin
         fall_clr_c = wdata[IN_WIDTH-1:0];
      end
   end

   // sticky edge flags
   always_ff @(posedge clk) begin
      if (reset) begin
         rise_q <= '0;
         fall_q <= '0;
      end else begin
         rise_q <= (rise_q & ~rise_clr_c) | rise_set_c;
         fall_q <= (fall_q & ~fall_clr_c) | fall_set_c;
      end
   end

   // interrupt enable register
   always_ff @(posedge clk) begin
      if (reset) begin
         irq_en_q <= '0;
      end else if (we && (addr == ADDR_IRQ_EN)) begin
         irq_en_q <= wdata[IN_WIDTH-1:0];
      end
   end

   // read mux over current register values, so a same-cycle write is not seen
   always_comb begin
      rd_mux_c = '0;
      case (addr)
         ADDR_DEB:    rd_mux_c = DATA_WIDTH'(deb_q);
         ADDR_RISE:   rd_mux_c = DATA_WIDTH'(rise_q);
         ADDR_FALL:   rd_mux_c = DATA_WIDTH'(fall_q);
         ADDR_IRQ_EN: rd_mux_c = DATA_WIDTH'(irq_en_q);
         default:     rd_mux_c = '0;
      endcase
   end

   // registered read data, held while re is low
   always_ff @(posedge clk) begin
      if (reset) begin
         rdata <= '0;
      end else if (re) begin
         rdata <= rd_mux_c;
      end
   end

   assign irq_nxt_c = |((rise_q | fall_q) & irq_en_q);

   // registered level interrupt
   always_ff @(posedge clk) begin
      if (reset) begin
         irq <= 1'b0;
      end else begin
         irq <= irq_nxt_c;
      end
   end

endmodule
